// File: rtl/pulse_div_pkg.sv
// Shared constants and helpers for the multi-channel pulse divider.
// Optional per-channel enable is selected with the PULSE_DIV_ENABLE_EN macro.
package pulse_div_pkg;

   localparam int MAX_CHANNELS_C = 16;
   localparam int DEFAULT_DIV_C  = 2;

   // A divisor of zero would never wrap, so it behaves as divide-by-one.
   function automatic logic [31:0] eff_div(input logic [31:0] v);
      return (v == '0) ? 32'd1 : v;
   endfunction

   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pulse_divider_mc_channel.sv
// One divider channel: input synchroniser, rising-edge counter, shadowed divisor.
// The en input is driven from ch_en only when PULSE_DIV_ENABLE_EN is defined.
module pulse_div_channel
   import pulse_div_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int DEFAULT_DIV = DEFAULT_DIV_C
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   input  logic             en,
   input  logic             div_wr,
   input  logic [CNT_W-1:0] div_val,
   output logic             tick,
   output logic             pulse_out,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEF_C = CNT_W'(eff_div(32'(DEFAULT_DIV)));

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sync_prev;
   logic                   r_tick;
   logic                   r_pulse;
   logic                   r_fresh;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       r_active;
   logic [CNT_W-1:0]       r_shadow;

   logic                   w_sync_out;
   logic                   w_rise;
   logic                   w_wrap;
   logic [CNT_W-1:0]       w_div_eff;
   logic [CNT_W-1:0]       w_shadow_next;
   logic [CNT_W-1:0]       w_cnt_next;

   assign w_sync_out    = r_sync[SYNC_STAGES-1];
   assign w_rise        = en & w_sync_out & ~r_sync_prev;
   assign w_wrap        = w_rise & (r_cnt == (r_active - ONE));
   assign w_div_eff     = CNT_W'(eff_div(32'(div_val)));
   assign w_shadow_next = div_wr ? w_div_eff : r_shadow;
   assign w_cnt_next    = w_wrap ? '0 : (w_rise ? (r_cnt + ONE) : r_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync      <= '0;
         r_sync_prev <= 1'b0;
         r_tick      <= 1'b0;
         r_pulse     <= 1'b0;
         r_fresh     <= 1'b1;
         r_cnt       <= '0;
         r_active    <= DEF_C;
         r_shadow    <= DEF_C;
      end else begin
         r_sync      <= {r_sync[SYNC_STAGES-2:0], pulse_in};
         r_sync_prev <= w_sync_out;
         r_shadow    <= w_shadow_next;
         r_tick      <= w_wrap;
         if (!en) begin
            // sync_prev keeps tracking, so enabling while the input is high is not a rise
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
            r_active <= w_shadow_next;
            r_fresh  <= 1'b1;
         end else begin
            r_cnt   <= w_cnt_next;
            r_pulse <= (r_active == ONE) ? w_sync_out : (w_cnt_next >= (r_active >> 1));
            // An idle channel takes a new divisor at once; a running one only at its wrap.
            if (w_wrap || (r_fresh && (r_cnt == '0) && !w_rise))
               r_active <= w_shadow_next;
            if (w_wrap)
               r_fresh <= 1'b1;
            else if (w_rise)
               r_fresh <= 1'b0;
         end
      end
   end

   assign tick      = r_tick;
   assign pulse_out = r_pulse;
   assign cnt       = r_cnt;

endmodule

// File: rtl/pulse_divider_mc.sv
// Multi-channel runtime-programmable edge divider with per-channel divisor writes.
// Define PULSE_DIV_ENABLE_EN to add the ch_en per-channel enable port.
module pulse_divider_mc
   import pulse_div_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int DEFAULT_DIV = DEFAULT_DIV_C
)
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [CHANNELS-1:0]             pulse_in,
`ifdef PULSE_DIV_ENABLE_EN
   input  logic [CHANNELS-1:0]             ch_en,
`endif
   input  logic                            div_wr,
   input  logic [ch_idx_w(CHANNELS)-1:0]   div_ch,
   input  logic [CNT_W-1:0]                div_val,
   output logic [CHANNELS-1:0]             tick,
   output logic [CHANNELS-1:0]             pulse_out,
   output logic [CHANNELS*CNT_W-1:0]       cnt
);

   logic [CHANNELS-1:0] w_en;
   logic [CHANNELS-1:0] w_wr;

`ifdef PULSE_DIV_ENABLE_EN
   assign w_en = ch_en;
`else
   assign w_en = '1;
`endif

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      // Indices at or above CHANNELS match no channel, so such writes are dropped.
      assign w_wr[g] = div_wr && (32'(div_ch) == g);

      pulse_div_channel #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .pulse_in  (pulse_in[g]),
         .en        (w_en[g]),
         .div_wr    (w_wr[g]),
         .div_val   (div_val),
         .tick      (tick[g]),
         .pulse_out (pulse_out[g]),
         .cnt       (cnt[g*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_pulse_divider_mc.sv
// Scoreboard bench for pulse_divider_mc; also covers ch_en when PULSE_DIV_ENABLE_EN is defined.
module tb_pulse_divider_mc;
   localparam int CH  = 4;
   localparam int CW  = 16;
   localparam int SS  = 2;
   localparam int DEF = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [CH-1:0]     pulse_in;
   logic              div_wr;
   logic [1:0]        div_ch;
   logic [CW-1:0]     div_val;
   logic [CH-1:0]     tick;
   logic [CH-1:0]     pulse_out;
   logic [CH*CW-1:0]  cnt;
`ifdef PULSE_DIV_ENABLE_EN
   logic [CH-1:0]     ch_en;
`endif

   always #5 clk = ~clk;

   pulse_divider_mc #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS), .DEFAULT_DIV(DEF)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pulse_in  (pulse_in),
`ifdef PULSE_DIV_ENABLE_EN
      .ch_en     (ch_en),
`endif
      .div_wr    (div_wr),
      .div_ch    (div_ch),
      .div_val   (div_val),
      .tick      (tick),
      .pulse_out (pulse_out),
      .cnt       (cnt)
   );

   typedef struct packed {
      logic          tk;
      logic          po;
      logic [CW-1:0] c;
   } exp_t;

   exp_t exp_q [CH][$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_act [CH];
   int   m_shd [CH];
   int   m_cnt [CH];
   bit   m_fresh [CH];
   bit   m_en [CH];
   int   tick_cnt [CH];
   logic [CW-1:0] prev_cnt [CH];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: each channel is an edge counter with an active and a pending divisor
   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < CH; i++) begin
         m_act[i] = DEF; m_shd[i] = DEF; m_cnt[i] = 0; m_fresh[i] = 1'b1;
      end
   endtask

   task automatic m_write(input int ch, input int v);
      if (ch >= CH) return;
      m_shd[ch] = eff(v);
      if (m_fresh[ch] || !m_en[ch]) m_act[ch] = m_shd[ch];
   endtask

   task automatic m_rise(input int ch);
      exp_t e;
      int   d;
      if (!m_en[ch]) return;
      d = m_act[ch];
      if (m_cnt[ch] + 1 == d) begin
         m_cnt[ch] = 0; e.tk = 1'b1; m_act[ch] = m_shd[ch]; m_fresh[ch] = 1'b1;
      end else begin
         m_cnt[ch]++; e.tk = 1'b0; m_fresh[ch] = 1'b0;
      end
      e.c  = CW'(m_cnt[ch]);
      e.po = (d == 1) ? 1'b1 : (m_cnt[ch] >= d / 2);
      exp_q[ch].push_back(e);
   endtask

   task automatic do_write(input int ch, input int v);
      @(negedge clk);
      div_wr = 1'b1; div_ch = 2'(ch); div_val = CW'(v);
      m_write(ch, v);
      @(negedge clk);
      div_wr = 1'b0;
   endtask

   task automatic do_rise(input logic [CH-1:0] mask, input int hi, input int lo);
      @(negedge clk);
      pulse_in = pulse_in | mask;
      for (int i = 0; i < CH; i++) if (mask[i]) m_rise(i);
      repeat (hi) @(negedge clk);
      pulse_in = pulse_in & ~mask;
      repeat (lo - 1) @(negedge clk);
   endtask

   // Divisor write timed to land in the same clock as the channel's wrap
   task automatic do_rise_wr(input int ch, input int v);
      @(negedge clk);
      pulse_in[ch] = 1'b1;
      m_write(ch, v);
      m_rise(ch);
      repeat (SS) @(negedge clk);
      div_wr = 1'b1; div_ch = 2'(ch); div_val = CW'(v);
      @(negedge clk);
      div_wr = 1'b0; pulse_in[ch] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Monitor: every counted edge shows up as a tick or a change of cnt
   initial begin
      logic [CW-1:0] c;
      exp_t          e;
      for (int i = 0; i < CH; i++) prev_cnt[i] = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < CH; i++) begin
            c = cnt[i*CW +: CW];
            if (!rst_n) begin
               prev_cnt[i] = '0;
            end else begin
               if (tick[i] || (c != prev_cnt[i])) begin
                  if (tick[i]) tick_cnt[i]++;
                  if (exp_q[i].size() == 0) begin
                     chk($sformatf("unexpected_event_ch%0d", i), 1, 0);
                  end else begin
                     e = exp_q[i].pop_front();
                     chk($sformatf("tick_ch%0d", i), tick[i], e.tk);
                     chk($sformatf("cnt_ch%0d", i), c, e.c);
                     chk($sformatf("pulse_out_ch%0d", i), pulse_out[i], e.po);
                  end
               end
               prev_cnt[i] = c;
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; pulse_in = '0; div_wr = 1'b0; div_ch = '0; div_val = '0;
`ifdef PULSE_DIV_ENABLE_EN
      ch_en = '1;
`endif
      for (int i = 0; i < CH; i++) begin m_en[i] = 1'b1; tick_cnt[i] = 0; end
      m_reset();
      repeat (3) @(negedge clk);
      chk("reset_tick", tick, 0);
      chk("reset_pulse_out", pulse_out, 0);
      chk("reset_cnt", cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Four divisors, 20 simultaneous edges
      do_write(0, 2); do_write(1, 4); do_write(2, 5); do_write(3, 8);
      for (int i = 0; i < CH; i++) tick_cnt[i] = 0;
      repeat (20) do_rise(4'hF, 2, 2);
      repeat (3) @(negedge clk);
      chk("t1_ticks_ch0", tick_cnt[0], 10);
      chk("t1_ticks_ch1", tick_cnt[1], 5);
      chk("t1_ticks_ch2", tick_cnt[2], 4);
      chk("t1_ticks_ch3", tick_cnt[3], 2);

      // Divisor 0 acts as 1; check the input-to-output latency
      do_write(1, 0);
      tick_cnt[1] = 0;
      @(negedge clk);
      pulse_in[1] = 1'b1;
      m_rise(1);
      @(posedge clk); #1;
      chk("lat_e1_tick", tick[1], 0);
      @(posedge clk); #1;
      chk("lat_e2_tick", tick[1], 0);
      chk("lat_e2_po", pulse_out[1], 0);
      @(posedge clk); #1;
      chk("lat_e3_tick", tick[1], 1);
      chk("lat_e3_po", pulse_out[1], 1);
      @(posedge clk); #1;
      chk("lat_e4_tick", tick[1], 0);
      @(negedge clk);
      pulse_in[1] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("lat_fall_e2_po", pulse_out[1], 1);
      @(posedge clk); #1;
      chk("lat_fall_e3_po", pulse_out[1], 0);
      repeat (5) do_rise(4'b0010, 2, 2);
      repeat (3) @(negedge clk);
      chk("t2_ticks_ch1", tick_cnt[1], 6);

      // Mid-period write waits for the current period to finish
      tick_cnt[0] = 0;
      do_write(0, 8);
      repeat (3) do_rise(4'b0001, 2, 2);
      do_write(0, 3);
      repeat (4) do_rise(4'b0001, 2, 2);
      chk("t3_no_tick_before_8th", tick_cnt[0], 0);
      do_rise(4'b0001, 2, 2);
      chk("t3_tick_at_8th", tick_cnt[0], 1);
      repeat (6) do_rise(4'b0001, 2, 2);
      chk("t3_two_short_periods", tick_cnt[0], 3);

      // Write coinciding with the wrap applies to the next period
      tick_cnt[0] = 0;
      repeat (2) do_rise(4'b0001, 2, 2);
      do_rise_wr(0, 4);
      chk("t4_wrap_tick", tick_cnt[0], 1);
      repeat (3) do_rise(4'b0001, 2, 2);
      chk("t4_no_tick_at_3rd", tick_cnt[0], 1);
      do_rise(4'b0001, 2, 2);
      chk("t4_tick_at_4th", tick_cnt[0], 2);

      // Async reset in the middle of a period
      do_write(0, 8);
      repeat (5) do_rise(4'b0001, 2, 2);
      chk("t5_cnt_before_rst", cnt[CW-1:0], 5);
      chk("t5_po_before_rst", pulse_out[0], 1);
      for (int i = 0; i < CH; i++) chk($sformatf("t5_q_empty_ch%0d", i), exp_q[i].size(), 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_tick", tick, 0);
      chk("t5_rst_pulse_out", pulse_out, 0);
      chk("t5_rst_cnt", cnt, 0);
      m_reset();
      for (int i = 0; i < CH; i++) exp_q[i].delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < CH; i++) tick_cnt[i] = 0;
      repeat (2) do_rise(4'hF, 2, 2);
      for (int i = 0; i < CH; i++) chk($sformatf("t5_default_div_ch%0d", i), tick_cnt[i], 1);

`ifdef PULSE_DIV_ENABLE_EN
      // Disabled channel ignores edges; re-enable while the input is high
      @(negedge clk);
      ch_en[2] = 1'b0; m_en[2] = 1'b0; m_act[2] = m_shd[2];
      tick_cnt[2] = 0;
      repeat (10) do_rise(4'b0100, 2, 2);
      chk("t6_dis_ticks", tick_cnt[2], 0);
      chk("t6_dis_cnt", cnt[2*CW +: CW], 0);
      @(negedge clk);
      pulse_in[2] = 1'b1;
      repeat (4) @(negedge clk);
      ch_en[2] = 1'b1; m_en[2] = 1'b1; m_cnt[2] = 0; m_fresh[2] = 1'b1;
      repeat (2) @(negedge clk);
      pulse_in[2] = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_reen_high_cnt", cnt[2*CW +: CW], 0);
      chk("t6_reen_high_ticks", tick_cnt[2], 0);
      repeat (2) do_rise(4'b0100, 2, 2);
      chk("t6_reen_ticks", tick_cnt[2], 1);
`endif

      // Random writes and edge bursts against the model
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) == 0)
            do_write($urandom_range(0, CH - 1), $urandom_range(0, 6));
         else
            do_rise(CH'($urandom_range(1, 15)), $urandom_range(2, 4), $urandom_range(2, 4));
      end

      repeat (6) @(negedge clk);
      for (int i = 0; i < CH; i++) chk($sformatf("final_q_empty_ch%0d", i), exp_q[i].size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
